// File: rtl/wb_regfile.sv
// Writeback stage: picks ALU or size-formatted load data, commits it to a 32-entry
// register file with write-first read bypass, and counts retired register writes.
module wb_regfile #(
   parameter int DATA_WIDTH   = 64,
   parameter int REG_ID_WIDTH = 5,
   parameter int CNT_WIDTH    = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [DATA_WIDTH-1:0]   alu_in,
   input  logic [DATA_WIDTH-1:0]   mem_data_in,
   input  logic [REG_ID_WIDTH-1:0] dest_in,
   input  logic [1:0]              wb_control_in,
   input  logic [2:0]              load_size_in,
   input  logic [REG_ID_WIDTH-1:0] rs1_addr,
   input  logic [REG_ID_WIDTH-1:0] rs2_addr,
   output logic [DATA_WIDTH-1:0]   rs1_data,
   output logic [DATA_WIDTH-1:0]   rs2_data,
   output logic [DATA_WIDTH-1:0]   wb_data_out,
   output logic                    wb_we_out,
   output logic [CNT_WIDTH-1:0]    retire_cnt
);

   localparam int NUM_REGS = 2 ** REG_ID_WIDTH;

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [CNT_WIDTH-1:0]  retire_cnt_q;
   logic [CNT_WIDTH-1:0]  retire_cnt_d;
   logic                  reg_write_s;
   logic                  mem_to_reg_s;

   function automatic logic [DATA_WIDTH-1:0] format_load(
      input logic [DATA_WIDTH-1:0] raw,
      input logic [2:0]            size
   );
      logic [DATA_WIDTH-1:0] res;
      case (size)
         3'b000:  res = {{(DATA_WIDTH-8){raw[7]}},   raw[7:0]};
         3'b001:  res = {{(DATA_WIDTH-16){raw[15]}}, raw[15:0]};
         3'b010:  res = {{(DATA_WIDTH-32){raw[31]}}, raw[31:0]};
         3'b100:  res = {{(DATA_WIDTH-8){1'b0}},     raw[7:0]};
         3'b101:  res = {{(DATA_WIDTH-16){1'b0}},    raw[15:0]};
         3'b110:  res = {{(DATA_WIDTH-32){1'b0}},    raw[31:0]};
         // 011 (LD) and the unused 111 encoding both pass the full word
         default: res = raw;
      endcase
      return res;
   endfunction

   // Writeback value select and effective write enable (x0 is never written)
   always_comb begin
      reg_write_s  = wb_control_in[1];
      mem_to_reg_s = wb_control_in[0];
      if (mem_to_reg_s) begin
         wb_data_out = format_load(mem_data_in, load_size_in);
      end else begin
         wb_data_out = alu_in;
      end
      wb_we_out    = reg_write_s && (dest_in != {REG_ID_WIDTH{1'b0}});
      retire_cnt_d = retire_cnt_q + CNT_WIDTH'(1);
   end

   // Read ports: x0 hard zero, then same-cycle write bypass, then array
   always_comb begin
      if (rs1_addr == {REG_ID_WIDTH{1'b0}}) begin
         rs1_data = {DATA_WIDTH{1'b0}};
      end else if (wb_we_out && (rs1_addr == dest_in)) begin
         rs1_data = wb_data_out;
      end else begin
         rs1_data = regs_q[rs1_addr];
      end
      if (rs2_addr == {REG_ID_WIDTH{1'b0}}) begin
         rs2_data = {DATA_WIDTH{1'b0}};
      end else if (wb_we_out && (rs2_addr == dest_in)) begin
         rs2_data = wb_data_out;
      end else begin
         rs2_data = regs_q[rs2_addr];
      end
   end

   // Register commit and retired-write counter; reset drops any pending write
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= {DATA_WIDTH{1'b0}};
         end
         retire_cnt_q <= {CNT_WIDTH{1'b0}};
      end else if (wb_we_out) begin
         regs_q[dest_in] <= wb_data_out;
         retire_cnt_q    <= retire_cnt_d;
      end
   end

   assign retire_cnt = retire_cnt_q;

endmodule
